// File: rtl/uart_pkg.sv
// Shared types, parity constants and the parity helper for the parametrised UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    CLEANUP = 3'd5
  } uart_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  localparam int MAX_DATA_WIDTH = 9;

  // Parity bit a correct transmitter sends; unused upper bits must be zero.
  function automatic logic parity_calc(input logic [MAX_DATA_WIDTH-1:0] data,
                                       input int mode);
    logic p;
    p = ^data;
    if (mode == PARITY_ODD) return ~p;
    else if (mode == PARITY_EVEN) return p;
    else return 1'b0;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop RX synchroniser; with UART_RX_MAJORITY_VOTE_EN it also provides a
// 3-tap majority of the synchronised line for noise-tolerant sampling.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic rx_serial,
  output logic line,
  output logic sample
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      line <= 1'b1;
    end else begin
      meta <= rx_serial;
      line <= meta;
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic line_d1;
  logic line_d2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_d1 <= 1'b1;
      line_d2 <= 1'b1;
    end else begin
      line_d1 <= line;
      line_d2 <= line_d1;
    end
  end

  // Window is the current line value plus the two before it.
  assign sample = (line & line_d1) | (line & line_d2) | (line_d1 & line_d2);
`else
  assign sample = line;
`endif

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with valid/ready output and overrun detection.
// Optional 3-tap majority sampling is enabled by defining UART_RX_MAJORITY_VOTE_EN.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_serial,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  frame_err,
  output logic                  parity_err,
  output logic                  overrun_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_WIDTH - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);

  localparam logic [2:0] ST_IDLE    = 3'(IDLE);
  localparam logic [2:0] ST_START   = 3'(START);
  localparam logic [2:0] ST_DATA    = 3'(DATA);
  localparam logic [2:0] ST_PARITY  = 3'(PARITY);
  localparam logic [2:0] ST_STOP    = 3'(STOP);
  localparam logic [2:0] ST_CLEANUP = 3'(CLEANUP);

  if (CLKS_PER_BIT < 4 || DATA_WIDTH < 5 || DATA_WIDTH > MAX_DATA_WIDTH ||
      PARITY_MODE < 0 || PARITY_MODE > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_err
    $error("uart_rx_param: illegal parameter combination");
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  if (CLKS_PER_BIT < 8) begin : g_vote_err
    $error("uart_rx_param: majority voting needs CLKS_PER_BIT >= 8");
  end
`endif

  logic                  line;
  logic                  sample;
  logic [2:0]            state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [3:0]            bit_idx;
  logic                  stop_idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  ferr_q;
  logic                  perr_q;
  logic                  tick;
  logic                  smp_en;
  logic                  smp_bit;

  uart_rx_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_serial (rx_serial),
    .line      (line),
    .sample    (sample)
  );

  always_comb begin
    tick = 1'b0;
    case (state)
      ST_START:                   tick = (bit_cnt == HALF_LAST);
      ST_DATA, ST_PARITY, ST_STOP: tick = (bit_cnt == BIT_LAST);
      default:                    tick = 1'b0;
    endcase
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic tick_d;

  // The majority needs the line value after the terminal count, so act a cycle late.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_d <= 1'b0;
    else        tick_d <= tick;
  end

  assign smp_en  = tick_d;
  assign smp_bit = sample;
`else
  assign smp_en  = tick;
  assign smp_bit = sample;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
    end else if (state == ST_IDLE || state == ST_CLEANUP || tick) begin
      bit_cnt <= '0;
    end else begin
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      ferr_q   <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          bit_idx  <= '0;
          stop_idx <= 1'b0;
          if (!line) begin
            state  <= ST_START;
            ferr_q <= 1'b0;
            perr_q <= 1'b0;
          end
        end
        ST_START: begin
          // A line back high at mid-bit was a glitch, not a start bit.
          if (smp_en) state <= smp_bit ? ST_IDLE : ST_DATA;
        end
        ST_DATA: begin
          if (smp_en) begin
            bit_idx <= bit_idx + 4'd1;
            if (bit_idx == DATA_LAST)
              state <= (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (smp_en) begin
            perr_q <= (smp_bit != parity_calc(MAX_DATA_WIDTH'(shreg), PARITY_MODE));
            state  <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (smp_en) begin
            if (!smp_bit) ferr_q <= 1'b1;
            stop_idx <= ~stop_idx;
            if (stop_idx == STOP_LAST) state <= ST_CLEANUP;
          end
        end
        ST_CLEANUP: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_DATA && smp_en) shreg <= {smp_bit, shreg[DATA_WIDTH-1:1]};
  end

  // A pending word is only replaced when the consumer takes it in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (state == ST_CLEANUP) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg;
          frame_err  <= ferr_q;
          parity_err <= perr_q;
          rx_valid   <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: three configurations driven with directed frames.
module tb_uart_rx_param;

  localparam int C = 16;
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int VOTE = 1;
`else
  localparam int VOTE = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] ser, rdy, vld, fe, pe, ov;
  logic [7:0] d0, d1;
  logic [8:0] d2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_param #(.CLKS_PER_BIT(C), .DATA_WIDTH(8), .PARITY_MODE(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .rx_serial(ser[0]), .rx_data(d0), .rx_valid(vld[0]),
    .rx_ready(rdy[0]), .frame_err(fe[0]), .parity_err(pe[0]), .overrun_err(ov[0]));

  uart_rx_param #(.CLKS_PER_BIT(C), .DATA_WIDTH(8), .PARITY_MODE(1), .STOP_BITS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .rx_serial(ser[1]), .rx_data(d1), .rx_valid(vld[1]),
    .rx_ready(rdy[1]), .frame_err(fe[1]), .parity_err(pe[1]), .overrun_err(ov[1]));

  uart_rx_param #(.CLKS_PER_BIT(C), .DATA_WIDTH(9), .PARITY_MODE(2), .STOP_BITS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .rx_serial(ser[2]), .rx_data(d2), .rx_valid(vld[2]),
    .rx_ready(rdy[2]), .frame_err(fe[2]), .parity_err(pe[2]), .overrun_err(ov[2]));

  typedef struct {
    logic [8:0] data;
    logic       fe;
    logic       pe;
    int         lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int n_tests = 0;
  int n_fail  = 0;
  int t0 [3];
  int ovr_cnt [3];

  task automatic chk(input string name, input int act, input int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  function automatic int qsize(input int ch);
    case (ch)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic push(input int ch, input logic [8:0] data, input logic f, input logic p,
                      input int lat);
    exp_t e;
    e.data = data; e.fe = f; e.pe = p; e.lat = lat;
    case (ch)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Cycles from the edge before the start bit to rx_valid rising.
  function automatic int lat_of(input int dw, input int par, input int stops);
    return C/2 + 3 + C*(dw + par + stops) + 1 + VOTE;
  endfunction

  task automatic check_xfer(input int ch);
    exp_t       e;
    logic [8:0] d;
    n_tests++;
    if (qsize(ch) == 0) begin
      n_fail++;
      $display("FAIL ch%0d_unexpected_word: got a word with no expected entry", ch);
    end else begin
      n_tests--;
      case (ch)
        0:       begin e = q0.pop_front(); d = {1'b0, d0}; end
        1:       begin e = q1.pop_front(); d = {1'b0, d1}; end
        default: begin e = q2.pop_front(); d = d2; end
      endcase
      chk($sformatf("ch%0d_data", ch), int'(d), int'(e.data));
      chk($sformatf("ch%0d_frame_err", ch), int'(fe[ch]), int'(e.fe));
      chk($sformatf("ch%0d_parity_err", ch), int'(pe[ch]), int'(e.pe));
      if (e.lat > 0) chk($sformatf("ch%0d_valid_latency", ch), cyc - t0[ch], e.lat);
    end
  endtask

  always @(negedge clk) begin
    for (int ch = 0; ch < 3; ch++) begin
      if (ov[ch]) ovr_cnt[ch]++;
      if (vld[ch] && rdy[ch]) check_xfer(ch);
    end
  end

  function automatic logic [15:0] frame(input logic [8:0] data, input int dw, input int par_en,
                                        input logic par_bit, input int stops, input logic stop_bit);
    logic [15:0] f;
    int k;
    f = '1; f[0] = 1'b0; k = 1;
    for (int i = 0; i < dw; i++) begin f[k] = data[i]; k++; end
    if (par_en != 0) begin f[k] = par_bit; k++; end
    for (int i = 0; i < stops; i++) begin f[k] = stop_bit; k++; end
    return f;
  endfunction

  task automatic send(input int ch, input logic [15:0] bits, input int n, input int dw,
                      input bit spike, input int gap);
    @(posedge clk); #1;
    t0[ch] = cyc;
    for (int i = 0; i < n; i++) begin
      ser[ch] = bits[i];
      if (spike && i >= 1 && i <= dw) begin
        repeat (C/2) @(posedge clk);
        #1 ser[ch] = ~bits[i];
        @(posedge clk);
        #1 ser[ch] = bits[i];
        repeat (C/2 - 1) @(posedge clk);
        #1;
      end else begin
        repeat (C) @(posedge clk);
        #1;
      end
    end
    ser[ch] = 1'b1;
    repeat (gap) @(posedge clk);
  endtask

  task automatic wait_drain(input int ch, input int budget);
    int k = 0;
    while (qsize(ch) != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    n_tests++;
    if (qsize(ch) != 0) begin
      n_fail++;
      $display("FAIL ch%0d_timeout: %0d words outstanding, expected 0", ch, qsize(ch));
    end
  endtask

  initial begin
    ser   = '1;
    rdy   = '1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", int'(vld), 0);
    chk("reset_frame_err", int'(fe), 0);
    chk("reset_parity_err", int'(pe), 0);
    chk("reset_overrun", int'(ov), 0);
    chk("reset_data0", int'(d0), 0);
    chk("reset_data2", int'(d2), 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Clean 8N1 word.
    push(0, 9'h0A5, 1'b0, 1'b0, lat_of(8, 0, 1));
    send(0, frame(9'h0A5, 8, 0, 1'b0, 1, 1'b1), 10, 8, 1'b0, 0);
    wait_drain(0, 50);
    @(negedge clk);
    chk("valid_one_cycle", int'(vld[0]), 0);

    // Even parity: 0x07 needs parity bit 1.
    push(1, 9'h007, 1'b0, 1'b1, lat_of(8, 1, 1));
    send(1, frame(9'h007, 8, 1, 1'b0, 1, 1'b1), 11, 8, 1'b0, 0);
    wait_drain(1, 50);
    push(1, 9'h007, 1'b0, 1'b0, lat_of(8, 1, 1));
    send(1, frame(9'h007, 8, 1, 1'b1, 1, 1'b1), 11, 8, 1'b0, 0);
    wait_drain(1, 50);

    // Broken stop bit, then a clean frame.
    push(0, 9'h03C, 1'b1, 1'b0, lat_of(8, 0, 1));
    send(0, frame(9'h03C, 8, 0, 1'b0, 1, 1'b0), 10, 8, 1'b0, 2*C);
    wait_drain(0, 50);
    push(0, 9'h055, 1'b0, 1'b0, lat_of(8, 0, 1));
    send(0, frame(9'h055, 8, 0, 1'b0, 1, 1'b1), 10, 8, 1'b0, 0);
    wait_drain(0, 50);

    // Overrun: consumer stalled across two back-to-back frames.
    rdy[0] = 1'b0;
    push(0, 9'h011, 1'b0, 1'b0, 0);
    send(0, frame(9'h011, 8, 0, 1'b0, 1, 1'b1), 10, 8, 1'b0, 0);
    send(0, frame(9'h022, 8, 0, 1'b0, 1, 1'b1), 10, 8, 1'b0, 0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("overrun_pulses", ovr_cnt[0], 1);
    chk("overrun_valid_held", int'(vld[0]), 1);
    chk("overrun_data_held", int'(d0), 8'h11);
    @(posedge clk); #1;
    rdy[0] = 1'b1;
    wait_drain(0, 5);
    @(negedge clk);
    @(negedge clk);
    chk("valid_drops_after_accept", int'(vld[0]), 0);

    // 5-clk low glitch on an idle line.
    @(posedge clk); #1;
    ser[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1 ser[0] = 1'b1;
    repeat (4*C) @(posedge clk);
    @(negedge clk);
    chk("glitch_no_valid", int'(vld[0]), 0);

    // Reset during data bit 4 of 0xF3; remaining bits are all high.
    fork
      send(0, frame(9'h0F3, 8, 0, 1'b0, 1, 1'b1), 10, 8, 1'b0, 0);
      begin
        repeat (C*5 + 6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_data", int'(d0), 0);
        chk("midreset_valid", int'(vld[0]), 0);
        chk("midreset_frame_err", int'(fe[0]), 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
      end
    join
    repeat (C) @(posedge clk);
    chk("after_midreset_no_valid", int'(vld[0]), 0);
    push(0, 9'h0F0, 1'b0, 1'b0, lat_of(8, 0, 1));
    send(0, frame(9'h0F0, 8, 0, 1'b0, 1, 1'b1), 10, 8, 1'b0, 0);
    wait_drain(0, 50);

    // 9 data bits, odd parity, 2 stop bits: 0x1AB has six ones, parity bit 1.
    push(2, 9'h1AB, 1'b0, 1'b0, lat_of(9, 1, 2));
    send(2, frame(9'h1AB, 9, 1, 1'b1, 2, 1'b1), 13, 9, 1'b0, 0);
    wait_drain(2, 50);
    push(2, 9'h1AB, 1'b0, 1'b1, lat_of(9, 1, 2));
    send(2, frame(9'h1AB, 9, 1, 1'b0, 2, 1'b1), 13, 9, 1'b0, 0);
    wait_drain(2, 50);
`ifdef UART_RX_MAJORITY_VOTE_EN
    push(2, 9'h1AB, 1'b0, 1'b0, lat_of(9, 1, 2));
    send(2, frame(9'h1AB, 9, 1, 1'b1, 2, 1'b1), 13, 9, 1'b1, 0);
    wait_drain(2, 50);
`endif

    repeat (2*C) @(posedge clk);
    chk("ch0_total_overruns", ovr_cnt[0], 1);
    chk("ch1_no_overrun", ovr_cnt[1], 0);
    chk("ch2_no_overrun", ovr_cnt[2], 0);
    chk("ch0_queue_empty", qsize(0), 0);
    chk("ch1_queue_empty", qsize(1), 0);
    chk("ch2_queue_empty", qsize(2), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
